// File: rtl/cic_decim_mc.sv
// Multi-channel CIC decimator. Integrators run at the input rate and the combs are pipelined
// at the output rate. A gain shift with round-to-nearest and saturation to WIDTH follows.
module cic_decim_mc #(
    parameter int BASE      = 0,
    parameter int NCH       = 2,
    parameter int WIDTH     = 24,
    parameter int STAGES    = 4,
    parameter int RATE_BITS = 8,
    parameter int ACC_WIDTH = WIDTH + STAGES * RATE_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 set_stb,
    input  logic [6:0]           set_addr,
    input  logic [31:0]          set_data,
    input  logic                 run,
    input  logic                 in_stb,
    input  logic [NCH*WIDTH-1:0] in_data,
    output logic                 out_stb,
    output logic [NCH*WIDTH-1:0] out_data,
    output logic [NCH-1:0]       sat_flag
);
    localparam int SHIFT_MAX = ACC_WIDTH - WIDTH;
    localparam logic [6:0] ADDR_RATE  = 7'(BASE);
    localparam logic [6:0] ADDR_SHIFT = 7'(BASE + 1);
    localparam logic [6:0] ADDR_SAT   = 7'(BASE + 2);

    typedef logic signed [ACC_WIDTH-1:0] acc_t;
    typedef logic signed [ACC_WIDTH:0]   rnd_t;

    function automatic int clog2_rate(input logic [RATE_BITS-1:0] r);
        int n;
        n = 0;
        for (int i = 0; i < RATE_BITS; i++)
            if ((64'd1 << i) < 64'(r)) n = i + 1;
        return n;
    endfunction

    function automatic rnd_t round_shift(input acc_t x, input int s);
        rnd_t v;
        v = rnd_t'(x);
        if (s > 0) v = v + (rnd_t'(1) <<< (s - 1));
        return v >>> s;
    endfunction

    // Result packs the clip indication above the saturated sample.
    function automatic logic [WIDTH:0] saturate(input rnd_t v);
        rnd_t hi, lo;
        logic [WIDTH:0] res;
        hi = rnd_t'({1'b0, {(WIDTH-1){1'b1}}});
        lo = ~hi;
        if (v > hi)      res = {1'b1, hi[WIDTH-1:0]};
        else if (v < lo) res = {1'b1, lo[WIDTH-1:0]};
        else             res = {1'b0, v[WIDTH-1:0]};
        return res;
    endfunction

    logic [RATE_BITS-1:0] rate_q, rate_d, cnt_q, cnt_d, r_m1;
    logic                 auto_q, auto_d, dec_q, dec_d, rvld_q, rvld_d, out_stb_q, out_stb_d;
    logic [5:0]           sman_q, sman_d;
    logic [STAGES-1:0]    cvld_q, cvld_d;
    logic [NCH-1:0]       sat_q, sat_d;
    logic [NCH*WIDTH-1:0] out_data_q, out_data_d;
    acc_t integ_q [NCH][STAGES];
    acc_t integ_d [NCH][STAGES];
    acc_t dly_q   [NCH][STAGES];
    acc_t dly_d   [NCH][STAGES];
    acc_t comb_q  [NCH][STAGES];
    acc_t comb_d  [NCH][STAGES];
    rnd_t rnd_q   [NCH];
    rnd_t rnd_d   [NCH];
    logic rate_wr, flush, accept;
    int   s_req, shift_eff;
    logic [WIDTH:0] sat_res;
    logic unused_set_bits;

    assign unused_set_bits = ^set_data[31:9];

    always_comb begin
        rate_d  = rate_q;
        auto_d  = auto_q;
        sman_d  = sman_q;
        sat_d   = sat_q;
        rate_wr = set_stb && (set_addr == ADDR_RATE);
        if (rate_wr) rate_d = set_data[RATE_BITS-1:0];
        if (set_stb && (set_addr == ADDR_SHIFT)) begin
            auto_d = set_data[8];
            sman_d = set_data[5:0];
        end
        if (set_stb && (set_addr == ADDR_SAT) && set_data[0]) sat_d = '0;

        // A rate write or run low discards every in-flight sample, including a coincident input.
        flush  = rate_wr || !run;
        accept = in_stb && !flush;
        s_req  = auto_q ? STAGES * clog2_rate(rate_q) : int'(sman_q);
        shift_eff = (s_req > SHIFT_MAX) ? SHIFT_MAX : s_req;

        // Input stage: decimation counter and integrator cascade
        r_m1  = (rate_q == '0) ? '0 : rate_q - 1'b1;
        cnt_d = cnt_q;
        dec_d = 1'b0;
        if (flush) cnt_d = '0;
        else if (accept) begin
            if (cnt_q >= r_m1) begin
                cnt_d = '0;
                dec_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        for (int k = 0; k < NCH; k++) begin
            for (int i = 0; i < STAGES; i++) begin
                integ_d[k][i] = flush ? '0 : integ_q[k][i];
                dly_d[k][i]   = flush ? '0 : dly_q[k][i];
                comb_d[k][i]  = flush ? '0 : comb_q[k][i];
            end
            if (accept) begin
                integ_d[k][0] = integ_q[k][0] + acc_t'(signed'(in_data[k*WIDTH +: WIDTH]));
                for (int i = 1; i < STAGES; i++)
                    integ_d[k][i] = integ_q[k][i] + integ_d[k][i-1];
            end
        end

        // Comb stages: one differentiator per clock, delays advance only on valid
        cvld_d = '0;
        if (!flush) begin
            cvld_d[0] = dec_q;
            for (int i = 1; i < STAGES; i++) cvld_d[i] = cvld_q[i-1];
            for (int k = 0; k < NCH; k++) begin
                if (dec_q) begin
                    comb_d[k][0] = integ_q[k][STAGES-1] - dly_q[k][0];
                    dly_d[k][0]  = integ_q[k][STAGES-1];
                end
                for (int i = 1; i < STAGES; i++) begin
                    if (cvld_q[i-1]) begin
                        comb_d[k][i] = comb_q[k][i-1] - dly_q[k][i];
                        dly_d[k][i]  = comb_q[k][i-1];
                    end
                end
            end
        end

        // Rounding stage
        rvld_d = !flush && cvld_q[STAGES-1];
        for (int k = 0; k < NCH; k++)
            rnd_d[k] = cvld_q[STAGES-1] ? round_shift(comb_q[k][STAGES-1], shift_eff) : rnd_q[k];

        // Saturation and output stage
        out_stb_d  = rvld_q && !flush;
        out_data_d = out_data_q;
        sat_res    = '0;
        if (out_stb_d) begin
            for (int k = 0; k < NCH; k++) begin
                sat_res = saturate(rnd_q[k]);
                out_data_d[k*WIDTH +: WIDTH] = sat_res[WIDTH-1:0];
                if (sat_res[WIDTH]) sat_d[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rate_q     <= RATE_BITS'(4);
            auto_q     <= 1'b1;
            sman_q     <= '0;
            cnt_q      <= '0;
            dec_q      <= 1'b0;
            cvld_q     <= '0;
            rvld_q     <= 1'b0;
            out_stb_q  <= 1'b0;
            out_data_q <= '0;
            sat_q      <= '0;
            for (int k = 0; k < NCH; k++) begin
                rnd_q[k] <= '0;
                for (int i = 0; i < STAGES; i++) begin
                    integ_q[k][i] <= '0;
                    dly_q[k][i]   <= '0;
                    comb_q[k][i]  <= '0;
                end
            end
        end else begin
            rate_q     <= rate_d;
            auto_q     <= auto_d;
            sman_q     <= sman_d;
            cnt_q      <= cnt_d;
            dec_q      <= dec_d;
            cvld_q     <= cvld_d;
            rvld_q     <= rvld_d;
            out_stb_q  <= out_stb_d;
            out_data_q <= out_data_d;
            sat_q      <= sat_d;
            for (int k = 0; k < NCH; k++) begin
                rnd_q[k] <= rnd_d[k];
                for (int i = 0; i < STAGES; i++) begin
                    integ_q[k][i] <= integ_d[k][i];
                    dly_q[k][i]   <= dly_d[k][i];
                    comb_q[k][i]  <= comb_d[k][i];
                end
            end
        end
    end

    assign out_stb  = out_stb_q;
    assign out_data = out_data_q;
    assign sat_flag = sat_q;
endmodule

// File: tb/tb_cic_decim_mc.sv
// Scoreboard bench for cic_decim_mc: stimulus queues expected samples and arrival cycles,
// and a negedge monitor pops and compares them whenever out_stb is seen.
module tb_cic_decim_mc;
    localparam int NCH = 2, WIDTH = 24, STAGES = 4, RATE_BITS = 8, LAT = STAGES + 2;

    logic                 clk = 1'b0;
    logic                 rst_n, set_stb, run, in_stb, out_stb;
    logic [6:0]           set_addr;
    logic [31:0]          set_data;
    logic [NCH*WIDTH-1:0] in_data, out_data;
    logic [NCH-1:0]       sat_flag;

    cic_decim_mc #(.BASE(0), .NCH(NCH), .WIDTH(WIDTH), .STAGES(STAGES), .RATE_BITS(RATE_BITS)) dut (
        .clk(clk), .rst_n(rst_n), .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
        .run(run), .in_stb(in_stb), .in_data(in_data), .out_stb(out_stb), .out_data(out_data),
        .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { bit chk; int v0; int v1; } exp_t;
    typedef struct { int cyc; bit chk; int v0; int v1; } sb_t;
    exp_t exp_q[$];
    sb_t  sb_q[$];
    int   checks = 0, failures = 0;
    int   b_rate = 4, b_cnt = 0;
    bit   nopush = 0;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, req, cyc);
        end
    endtask

    sb_t mon_e;
    logic signed [WIDTH-1:0] mon_o0, mon_o1;
    always @(negedge clk) begin
        if (rst_n && out_stb) begin
            if (sb_q.size() == 0) check("unexpected_out_stb", 1, 0);
            else begin
                mon_e  = sb_q.pop_front();
                mon_o0 = out_data[WIDTH-1:0];
                mon_o1 = out_data[2*WIDTH-1:WIDTH];
                check("out_cycle", cyc, mon_e.cyc);
                if (mon_e.chk) begin
                    check("out_ch0", mon_o0, mon_e.v0);
                    check("out_ch1", mon_o1, mon_e.v1);
                end
            end
        end
    end

    // One input cycle, plus a bench model of the decimation counter.
    task automatic step(input bit stb, input int x0 = 0, input int x1 = 0, input bit rn = 1,
                        input bit wr = 0, input int a = 0, input int d = 0);
        exp_t ex;
        sb_t  s;
        @(negedge clk);
        in_stb   = stb;
        in_data  = {x1[WIDTH-1:0], x0[WIDTH-1:0]};
        run      = rn;
        set_stb  = wr;
        set_addr = a[6:0];
        set_data = d;
        if (!rn) b_cnt = 0;
        else if (wr && a == 0) begin
            b_rate = (d[7:0] == 0) ? 1 : int'(d[7:0]);
            b_cnt  = 0;
        end else if (stb) begin
            b_cnt++;
            if (b_cnt == b_rate) begin
                b_cnt = 0;
                if (!nopush) begin
                    if (exp_q.size() != 0) ex = exp_q.pop_front();
                    else ex = '{chk: 1'b0, v0: 0, v1: 0};
                    s = '{cyc: cyc + 1 + LAT, chk: ex.chk, v0: ex.v0, v1: ex.v1};
                    sb_q.push_back(s);
                end
            end
        end
    endtask

    task automatic stream(input int n, input int x0, input int x1);
        for (int i = 0; i < n; i++) step(1'b1, x0, x1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0);
    endtask

    task automatic wreg(input int a, input int d);
        step(1'b0, 0, 0, 1'b1, 1'b1, a, d);
    endtask

    task automatic expect_val(input bit chk, input int v0, input int v1);
        exp_t e;
        e = '{chk: chk, v0: v0, v1: v1};
        exp_q.push_back(e);
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b1; in_stb = 1'b0; in_data = '0;
        set_stb = 1'b0; set_addr = '0; set_data = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("reset_out_stb", out_stb, 0);
        check("reset_out_data", out_data, 0);
        check("reset_sat_flag", sat_flag, 0);

        // DC at reset-default rate 4 / auto shift, with an unrelated write mid-stream
        expect_val(1, 137, 137); expect_val(1, 742, 742); expect_val(1, 996, 996);
        expect_val(1, 1000, 1000); expect_val(1, 1000, 1000);
        stream(9, 1000, 1000);
        step(1'b1, 1000, 1000, 1'b1, 1'b1, 5, 0);
        stream(10, 1000, 1000);
        idle(10);

        // Rate 8 with distinct channels, flushed mid-frame and on a decimating input
        wreg(0, 8);
        expect_val(1, 8, -24); expect_val(1, 62, -187);
        stream(22, 100, -300);
        step(1'b1, 100, -300, 1'b1, 1'b1, 0, 8);
        expect_val(1, 8, -24); expect_val(1, 62, -187); expect_val(1, 98, -295);
        expect_val(1, 100, -300);
        stream(39, 100, -300);
        step(1'b1, 100, -300, 1'b1, 1'b1, 0, 8);
        expect_val(1, 8, -24);
        stream(8, 100, -300);
        idle(10);

        // Full scale at rate 255, auto shift 32
        wreg(0, 255);
        for (int i = 0; i < 3; i++) expect_val(0, 0, 0);
        for (int i = 0; i < 3; i++) expect_val(1, -8258302, 8258301);
        stream(6 * 255, -8388608, 8388607);
        idle(10);
        check("fullscale_sat_flag", sat_flag, 0);

        // Manual shift 0 at rate 2 saturates both rails; then write-1-clear
        wreg(1, 0);
        wreg(0, 2);
        expect_val(1, 5000000, -5000000); expect_val(1, 8388607, -8388608);
        expect_val(1, 8388607, -8388608);
        stream(6, 1000000, -1000000);
        idle(10);
        check("sat_flag_set", sat_flag, 2'b11);
        wreg(2, 1);
        idle(1);
        check("sat_flag_cleared", sat_flag, 0);

        // Impulse at rate 1, one output per input
        wreg(0, 1);
        expect_val(1, 1, -5);
        for (int i = 0; i < 4; i++) expect_val(1, 0, 0);
        step(1'b1, 1, -5);
        stream(4, 0, 0);
        idle(10);

        // run low kills an in-flight output and holds the block flushed
        wreg(1, 32'h100);
        wreg(0, 4);
        stream(3, 1000, 1000);
        nopush = 1;
        step(1'b1, 1000, 1000);
        nopush = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1000, 1000, 1'b0);
            check("run_low_out_stb", out_stb, 0);
        end
        expect_val(1, 137, 137); expect_val(1, 742, 742); expect_val(1, 996, 996);
        expect_val(1, 1000, 1000);
        stream(16, 1000, 1000);
        idle(10);

        // Asynchronous reset mid-stream restores rate 4 and auto shift
        wreg(1, 3);
        wreg(0, 8);
        nopush = 1;
        stream(10, 1000, 1000);
        @(posedge clk);
        #2 rst_n = 1'b0;
        in_stb = 1'b0;
        #1;
        check("async_rst_out_stb", out_stb, 0);
        check("async_rst_out_data", out_data, 0);
        check("async_rst_sat_flag", sat_flag, 0);
        @(negedge clk);
        rst_n = 1'b1;
        nopush = 0; b_rate = 4; b_cnt = 0;
        expect_val(1, 137, 137); expect_val(1, 742, 742); expect_val(1, 996, 996);
        expect_val(1, 1000, 1000);
        stream(16, 1000, 1000);

        for (int i = 0; i < 50 && sb_q.size() != 0; i++) idle(1);
        idle(10);
        check("pending_outputs", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
